// File: rtl/snitch_pkg.sv
// Shared types for the cluster performance counter bank.
// Core event vector, counter config layout and address stride.
package snitch_pkg;

  typedef enum logic [2:0] {
    EvRetiredAcc     = 3'd0,
    EvRetiredInstr   = 3'd1,
    EvRetiredLoad    = 3'd2,
    EvRetiredI       = 3'd3,
    EvIssueFpuSeq    = 3'd4,
    EvIssueCoreToFpu = 3'd5,
    EvIssueFpu       = 3'd6,
    EvNone           = 3'd7
  } core_event_sel_e;

  // Bit 0 (last member) is retired_acc.
  typedef struct packed {
    logic issue_fpu;
    logic issue_core_to_fpu;
    logic issue_fpu_seq;
    logic retired_i;
    logic retired_load;
    logic retired_instr;
    logic retired_acc;
  } core_events_t;

  typedef struct packed {
    logic [7:0]      rsvd3;
    logic [7:0]      hart_sel;
    logic [4:0]      rsvd2;
    core_event_sel_e event_sel;
    logic [2:0]      rsvd1;
    logic            irq_en;
    logic            overflow;
    logic            saturate;
    logic            sum_mode;
    logic            enable;
  } perf_cfg_t;

  localparam int unsigned PerfCfgStride = 2;

  function automatic perf_cfg_t perf_cfg_clean(
    input perf_cfg_t c
  );
    perf_cfg_t r;
    r       = c;
    r.rsvd1 = '0;
    r.rsvd2 = '0;
    r.rsvd3 = '0;
    return r;
  endfunction

endpackage

// File: rtl/snitch_event_counter.sv
// One performance counter with its CFG register and update logic.
// Ports: clk_i/rst_i, events_i (registered), cfg_we_i/val_we_i, wdata_i, cfg_o, value_o.
module snitch_event_counter
  import snitch_pkg::*;
#(
  parameter int unsigned NumCores     = 8,
  parameter int unsigned CounterWidth = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  core_events_t [NumCores-1:0]    events_i,
  input  logic                           cfg_we_i,
  input  logic                           val_we_i,
  input  logic [31:0]                    wdata_i,
  output perf_cfg_t                      cfg_o,
  output logic [CounterWidth-1:0]        value_o
);

  localparam int unsigned IncW = $clog2(NumCores + 1);

  perf_cfg_t               cfg_q, cfg_d;
  logic [CounterWidth-1:0] val_q, val_d;
  logic [NumCores-1:0]     sel_bits;
  logic [IncW-1:0]         inc;
  logic [CounterWidth:0]   sum;
  logic                    ovf;
  logic                    ovf_set;

  // Padding to 8 bits makes event_sel 7 select a constant 0.
  always_comb begin
    sel_bits = '0;
    for (int h = 0; h < NumCores; h++) begin
      logic [7:0] ev8;
      ev8 = {1'b0, events_i[h]};
      sel_bits[h] = ev8[cfg_q.event_sel];
    end
  end

  // Out-of-range hart_sel never matches, giving inc = 0.
  always_comb begin
    inc = '0;
    if (cfg_q.enable) begin
      for (int h = 0; h < NumCores; h++) begin
        if (cfg_q.sum_mode) begin
          inc = inc + IncW'(sel_bits[h]);
        end else if (cfg_q.hart_sel == 8'(h)) begin
          inc = IncW'(sel_bits[h]);
        end
      end
    end
  end

  assign sum     = {1'b0, val_q} + (CounterWidth + 1)'(inc);
  assign ovf     = sum[CounterWidth];
  assign ovf_set = ovf & ~val_we_i;

  always_comb begin
    val_d = sum[CounterWidth-1:0];
    if (val_we_i) begin
      val_d = wdata_i[CounterWidth-1:0];
    end else if (ovf && cfg_q.saturate) begin
      val_d = '1;
    end
  end

  // Hardware overflow set beats a same-cycle W1C clear.
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_we_i) begin
      cfg_d          = perf_cfg_clean(perf_cfg_t'(wdata_i));
      cfg_d.overflow = cfg_q.overflow & ~wdata_i[3];
    end
    if (ovf_set) begin
      cfg_d.overflow = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q <= '0;
      val_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      val_q <= val_d;
    end
  end

  assign cfg_o   = cfg_q;
  assign value_o = val_q;

endmodule

// File: rtl/snitch_event_counter_bank.sv
// Bank of configurable per-hart event counters with word-addressed config port.
// Ports: clk_i/rst_i, core_events_i, cfg_* request, rsp_* response, irq_o.
module snitch_event_counter_bank
  import snitch_pkg::*;
#(
  parameter int unsigned NumCores     = 8,
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned CounterWidth = 32,
  parameter int unsigned AddrWidth    = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  core_events_t [NumCores-1:0] core_events_i,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic                        cfg_write_i,
  input  logic [AddrWidth-1:0]        cfg_addr_i,
  input  logic [31:0]                 cfg_wdata_i,
  output logic                        rsp_valid_o,
  output logic [31:0]                 rsp_rdata_o,
  output logic                        rsp_error_o,
  output logic                        irq_o
);

  core_events_t [NumCores-1:0] ev_q;
  perf_cfg_t                   cfg   [NumCounters];
  logic [CounterWidth-1:0]     val   [NumCounters];
  logic [NumCounters-1:0]      cfg_we;
  logic [NumCounters-1:0]      val_we;
  logic [NumCounters-1:0]      irq_src;
  logic                        wr;
  logic                        hit;
  logic [31:0]                 rdata_d;
  logic                        rsp_valid_q;
  logic [31:0]                 rsp_rdata_q;
  logic                        rsp_error_q;
  logic                        irq_q;

  assign cfg_ready_o = 1'b1;
  assign wr          = cfg_valid_i & cfg_write_i;

  for (genvar i = 0; i < NumCounters; i++) begin : g_cnt
    localparam int unsigned Base = PerfCfgStride * i;

    assign cfg_we[i]  = wr && (cfg_addr_i == AddrWidth'(Base));
    assign val_we[i]  = wr && (cfg_addr_i == AddrWidth'(Base + 1));
    assign irq_src[i] = cfg[i].overflow & cfg[i].irq_en;

    snitch_event_counter #(
      .NumCores     (NumCores),
      .CounterWidth (CounterWidth)
    ) i_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .events_i (ev_q),
      .cfg_we_i (cfg_we[i]),
      .val_we_i (val_we[i]),
      .wdata_i  (cfg_wdata_i),
      .cfg_o    (cfg[i]),
      .value_o  (val[i])
    );
  end

  // Reads see register state from before any same-cycle update.
  always_comb begin
    rdata_d = '0;
    hit     = 1'b0;
    for (int i = 0; i < NumCounters; i++) begin
      if (cfg_addr_i == AddrWidth'(PerfCfgStride * i)) begin
        rdata_d = cfg[i];
        hit     = 1'b1;
      end
      if (cfg_addr_i == AddrWidth'(PerfCfgStride * i + 1)) begin
        rdata_d = 32'(val[i]);
        hit     = 1'b1;
      end
    end
    if (cfg_write_i || !hit) begin
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ev_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ev_q        <= core_events_i;
      rsp_valid_q <= cfg_valid_i;
      rsp_rdata_q <= cfg_valid_i ? rdata_d : '0;
      rsp_error_q <= cfg_valid_i & ~hit;
      irq_q       <= |irq_src;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_snitch_event_counter_bank.sv
// Directed self-checking bench for snitch_event_counter_bank.
// Small config: 8 harts, 4 counters, 8-bit counters.
module tb_snitch_event_counter_bank;

  localparam int NC = 8;
  localparam int NK = 4;
  localparam int CW = 8;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC-1:0][6:0] ev = '0;
  logic              valid = 1'b0;
  logic              ready;
  logic              write = 1'b0;
  logic [AW-1:0]     addr = '0;
  logic [31:0]       wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic              irq;

  int pass_cnt = 0;
  int total = 0;

  logic        r_valid;
  logic [31:0] r_data;
  logic        r_err;

  always #5 clk = ~clk;

  snitch_event_counter_bank #(
    .NumCores     (NC),
    .NumCounters  (NK),
    .CounterWidth (CW),
    .AddrWidth    (AW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .core_events_i (ev),
    .cfg_valid_i   (valid),
    .cfg_ready_o   (ready),
    .cfg_write_i   (write),
    .cfg_addr_i    (addr),
    .cfg_wdata_i   (wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_error_o   (rsp_error),
    .irq_o         (irq)
  );

  task automatic req(input logic w, input logic [AW-1:0] a,
                     input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1;
    write = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
    valid   = 1'b0;
    write   = 1'b0;
    r_valid = rsp_valid;
    r_data  = rsp_rdata;
    r_err   = rsp_error;
  endtask

  task automatic pulse(input int b, input logic [NC-1:0] harts,
                       input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int h = 0; h < NC; h++) ev[h] = harts[h] ? 7'(1 << b) : 7'd0;
    end
    @(negedge clk);
    ev = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || irq !== 1'b0 || rsp_rdata !== 32'd0)
      $display("FAIL reset_out: valid=%b irq=%b rdata=%h want 0",
               rsp_valid, irq, rsp_rdata);
    else pass_cnt++;
    rst = 1'b0;
    req(1'b0, 8'd1, 32'd0);
    total++;
    if (r_valid !== 1'b1 || r_data !== 32'd0 || r_err !== 1'b0)
      $display("FAIL reset_val0: v=%b d=%h e=%b want 1/0/0",
               r_valid, r_data, r_err);
    else pass_cnt++;
    total++;
    if (ready !== 1'b1)
      $display("FAIL ready: got %b want 1", ready);
    else pass_cnt++;
  endtask

  task automatic test_single_hart;
    req(1'b1, 8'd0, 32'h0003_0201);
    pulse(2, 8'b0000_1100, 5);
    req(1'b0, 8'd1, 32'd0);
    total++;
    if (r_data !== 32'd5)
      $display("FAIL single_hart: got %0d want 5", r_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    ev[3] = 7'b000_0100;
    valid = 1'b1;
    write = 1'b0;
    addr  = 8'd1;
    @(negedge clk);
    ev = '0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd5)
      $display("FAIL stale_t: v=%b got %0d want 1/5", rsp_valid, rsp_rdata);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (rsp_rdata !== 32'd5)
      $display("FAIL stale_t1: got %0d want 5", rsp_rdata);
    else pass_cnt++;
    @(negedge clk);
    valid = 1'b0;
    total++;
    if (rsp_rdata !== 32'd6)
      $display("FAIL fresh_t2: got %0d want 6", rsp_rdata);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0)
      $display("FAIL rsp_one_cycle: got %b want 0", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_sum;
    req(1'b1, 8'd2, 32'h0000_0003);
    pulse(0, 8'hFF, 3);
    req(1'b0, 8'd3, 32'd0);
    total++;
    if (r_data !== 32'd24)
      $display("FAIL sum_mode: got %0d want 24", r_data);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    req(1'b1, 8'd5, 32'h0000_00FE);
    req(1'b1, 8'd4, 32'h0000_0013);
    pulse(0, 8'h0F, 1);
    @(negedge clk);
    total++;
    if (irq !== 1'b0)
      $display("FAIL irq_early: got %b want 0", irq);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (irq !== 1'b1)
      $display("FAIL irq_set: got %b want 1", irq);
    else pass_cnt++;
    req(1'b0, 8'd5, 32'd0);
    total++;
    if (r_data !== 32'h02)
      $display("FAIL wrap_val: got %h want 02", r_data);
    else pass_cnt++;
    req(1'b0, 8'd4, 32'd0);
    total++;
    if (r_data !== 32'h1B)
      $display("FAIL wrap_ovf: got %h want 1b", r_data);
    else pass_cnt++;
    req(1'b1, 8'd4, 32'h0000_0013);
    req(1'b0, 8'd4, 32'd0);
    total++;
    if (r_data !== 32'h1B)
      $display("FAIL w0_keeps: got %h want 1b", r_data);
    else pass_cnt++;
    req(1'b1, 8'd4, 32'h0000_001B);
    @(negedge clk);
    total++;
    if (irq !== 1'b0)
      $display("FAIL irq_clr: got %b want 0", irq);
    else pass_cnt++;
    req(1'b0, 8'd4, 32'd0);
    total++;
    if (r_data !== 32'h13)
      $display("FAIL w1c: got %h want 13", r_data);
    else pass_cnt++;
  endtask

  task automatic test_saturate;
    req(1'b1, 8'd7, 32'h0000_00FE);
    req(1'b1, 8'd6, 32'h0000_0007);
    pulse(0, 8'h0F, 1);
    req(1'b0, 8'd7, 32'd0);
    total++;
    if (r_data !== 32'hFF)
      $display("FAIL sat_val: got %h want ff", r_data);
    else pass_cnt++;
    req(1'b0, 8'd6, 32'd0);
    total++;
    if (r_data !== 32'h0F)
      $display("FAIL sat_ovf: got %h want 0f", r_data);
    else pass_cnt++;
    pulse(0, 8'h0F, 2);
    req(1'b0, 8'd7, 32'd0);
    total++;
    if (r_data !== 32'hFF)
      $display("FAIL sat_hold: got %h want ff", r_data);
    else pass_cnt++;
  endtask

  task automatic test_collision;
    @(negedge clk);
    for (int h = 0; h < NC; h++) ev[h] = 7'd1;
    @(negedge clk);
    ev    = '0;
    valid = 1'b1;
    write = 1'b1;
    addr  = 8'd3;
    wdata = 32'h10;
    @(negedge clk);
    valid = 1'b0;
    write = 1'b0;
    req(1'b0, 8'd3, 32'd0);
    total++;
    if (r_data !== 32'h10)
      $display("FAIL val_collide: got %h want 10", r_data);
    else pass_cnt++;
    req(1'b1, 8'd5, 32'h0000_00FF);
    @(negedge clk);
    ev[0] = 7'd1;
    @(negedge clk);
    ev    = '0;
    valid = 1'b1;
    write = 1'b1;
    addr  = 8'd4;
    wdata = 32'h0B;
    @(negedge clk);
    valid = 1'b0;
    write = 1'b0;
    req(1'b0, 8'd4, 32'd0);
    total++;
    if (r_data !== 32'h0B)
      $display("FAIL cfg_collide: got %h want 0b", r_data);
    else pass_cnt++;
    req(1'b0, 8'd5, 32'd0);
    total++;
    if (r_data !== 32'h00)
      $display("FAIL cfg_coll_val: got %h want 00", r_data);
    else pass_cnt++;
  endtask

  task automatic test_error;
    req(1'b0, 8'd8, 32'd0);
    total++;
    if (r_valid !== 1'b1 || r_err !== 1'b1 || r_data !== 32'd0)
      $display("FAIL err_read: v=%b e=%b d=%h want 1/1/0",
               r_valid, r_err, r_data);
    else pass_cnt++;
    req(1'b1, 8'd9, 32'hFFFF_FFFF);
    total++;
    if (r_err !== 1'b1)
      $display("FAIL err_write: e=%b want 1", r_err);
    else pass_cnt++;
    req(1'b0, 8'd1, 32'd0);
    total++;
    if (r_err !== 1'b0 || r_data !== 32'd6)
      $display("FAIL err_no_side: e=%b d=%0d want 0/6", r_err, r_data);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    pulse(2, 8'b0000_1000, 2);
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b1;
    write = 1'b0;
    addr  = 8'd1;
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b0)
      $display("FAIL rst_drop: got %b want 0", rsp_valid);
    else pass_cnt++;
    for (int k = 0; k < 2 * NK; k++) begin
      req(1'b0, AW'(k), 32'd0);
      total++;
      if (r_data !== 32'd0)
        $display("FAIL rst_reg%0d: got %h want 0", k, r_data);
      else pass_cnt++;
    end
    total++;
    if (irq !== 1'b0)
      $display("FAIL rst_irq: got %b want 0", irq);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_hart();
    test_back_to_back();
    test_sum();
    test_wrap();
    test_saturate();
    test_collision();
    test_error();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/snitch_event_counter_bank.md
Name: snitch_event_counter_bank

Overview:
- Parametrised bank of performance counters that counts per-core event strobes (core_events_t) from NumCores harts.
- Each counter has a runtime-selectable event and hart, or an all-harts sum mode.
- Supports wrap or saturate overflow, a sticky overflow flag and an interrupt output.
- Sits in the cluster peripherals; succeeds the fixed one-counter-per-event scheme with configurable channel count and mode.

Parameters:
- NumCores, 8, number of harts whose core_events_t vectors are observed (1..256)
- NumCounters, 4, number of independent counters (1..64)
- CounterWidth, 32, counter width in bits (8..32)
- AddrWidth, 8, config address width; must hold 2*NumCounters

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- core_events_i  in  NumCores x core_events_t  per-hart event strobes, one-cycle pulses
- cfg_valid_i  in  1  config request valid
- cfg_ready_o  out  1  config request ready; tied 1
- cfg_write_i  in  1  1 = write, 0 = read
- cfg_addr_i  in  AddrWidth  word address
- cfg_wdata_i  in  32  write data
- rsp_valid_o  out  1  response valid, one cycle after request
- rsp_rdata_o  out  32  read data
- rsp_error_o  out  1  address out of range
- irq_o  out  1  OR of (overflow & irq_en) over all counters

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active high; ports are named clk_i and rst_i.
- Reset values:
  - all counter values and config fields are 0
  - rsp_valid_o, rsp_rdata_o, rsp_error_o and irq_o are 0
  - the event input register is 0
- Reset in the middle of a request drops that request; no response is issued.
- Address map (word addresses):
  - 2i = CFG of counter i, with fields:
    - [0] enable
    - [1] sum_mode
    - [2] saturate
    - [3] overflow: sticky, write-1-to-clear; writing 0 leaves it unchanged
    - [4] irq_en
    - [10:8] event_sel: bit index into core_events_t, 0 = retired_acc … 6 = issue_fpu
    - [23:16] hart_sel
  - 2i+1 = VALUE of counter i, zero-extended to 32 bits; writes truncate to CounterWidth.
  - Addresses >= 2*NumCounters: rsp_error_o = 1 and rdata = 0; writes are ignored.
- Pipeline: core_events_i is registered once (stage E). The counter updates at the following edge. A strobe in cycle t is therefore visible in VALUE reads issued in cycle t+2 or later.
- Increment inc (width $clog2(NumCores+1)):
  - sum_mode = 0: inc = event bit of hart hart_sel. If hart_sel >= NumCores, inc = 0.
  - sum_mode = 1: inc = popcount of the selected event bit across all harts; hart_sel is ignored.
  - event_sel 7 yields inc = 0.
  - enable = 0 forces inc = 0.
- Update, computed at CounterWidth+1 bits:
  - wrap mode: value <= (value + inc) mod 2^CounterWidth. Set overflow if the carry is 1.
  - saturate mode: if the sum exceeds max, value <= 2^CounterWidth-1 and overflow is set. Once at max, the value holds.
- Write to a counter's VALUE in the same cycle as an increment: the write wins and that cycle's increment is lost.
- CFG write in the same cycle an overflow is detected: the hardware set of overflow wins over a W1C clear. Other CFG fields take the written value.
- Reads return the register state before any same-cycle update.
- Responses: every accepted request gives exactly one response, with rsp_valid_o high for one cycle at t+1. There is no back-pressure on responses.
- irq_o is registered and asserts the cycle after overflow is set with irq_en = 1.

Decomposition:
- snitch_pkg additions:
  - core_event_sel_e: 3-bit enum naming the core_events_t bit positions
  - perf_cfg_t: packed struct of the CFG fields
  - localparam PerfCfgStride = 2
- Sub-module snitch_event_counter: one counter plus its CFG register and increment/overflow logic, instantiated NumCounters times.
- The top level holds the input register stage, address decode, read mux and IRQ reduction.

Test Plan:
- Single-hart counting: counter 0 with CFG = 0x0003_0201 (enable, event_sel 2 = retired_load, hart_sel 3). Pulse hart 3 retired_load for 5 cycles and hart 2 for 5 cycles. VALUE0 reads 5; reads before t+2 show the stale value.
- Sum mode: CFG1 = enable | sum_mode, event_sel 0. All 8 harts assert retired_acc for 3 cycles. VALUE1 = 24.
- Wrap: CounterWidth = 8, VALUE written to 0xFE, sum mode, 4 harts pulse once. VALUE = 0x02, overflow = 1, irq_o = 1 the next cycle when irq_en is set. Writing CFG bit 3 = 1 clears overflow and irq_o drops.
- Saturate: same setup as wrap with saturate = 1. VALUE = 0xFF, overflow = 1; further pulses keep 0xFF.
- Collision: VALUE write 0x10 in the same cycle as a registered increment gives 0x10. A CFG write clearing overflow in the same cycle as a new overflow leaves overflow = 1.
- Error and reset: read addr 2*NumCounters gives rsp_error_o = 1 and rdata = 0. Asserting rst_i mid-count gives every VALUE = 0 and no response for a request issued in the reset cycle.
